// File: rtl/usb_cmd_pkg.sv
// rtl/usb_cmd_pkg.sv - shared encodings for the USB command parser
package usb_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_COMMIT
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;

  localparam logic [1:0] ERR_CSUM    = 2'd0;
  localparam logic [1:0] ERR_CMD     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/usb_cmd_payload_buf.sv
// rtl/usb_cmd_payload_buf.sv - packet payload holding buffer
// One write port filled during PAYLOAD, one combinational read port used while committing.
module usb_cmd_payload_buf #(
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Out-of-range indices only occur for non-power-of-two depths and are never consumed.
  assign rd_data = (int'(rd_idx) < MAX_LEN) ? mem[rd_idx] : 8'h00;

endmodule

// File: rtl/usb_cmd_parser.sv
// rtl/usb_cmd_parser.sv - frames USB command packets and commits checksum-verified register writes
module usb_cmd_parser
  import usb_cmd_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  state_t           state;
  logic [7:0]       sum;
  logic [7:0]       base_addr;
  logic [7:0]       len;
  logic [7:0]       idx;
  logic [TMR_W-1:0] timer;
  logic             xfer;
  logic             in_pkt;
  logic             timeout;
  logic             buf_we;
  logic [7:0]       sum_nxt;
  logic [7:0]       buf_rdata;

  assign xfer    = rx_valid & rx_ready;
  assign in_pkt  = (state != ST_IDLE) && (state != ST_COMMIT);
  assign sum_nxt = sum + rx_data;
  // Timeout is judged on the idle count alone, so a byte arriving in that cycle is dropped.
  assign timeout = in_pkt && (timer == TMR_LAST);
  assign buf_we  = xfer && (state == ST_PAYLOAD) && !timeout;
  assign busy    = (state != ST_IDLE);

  usb_cmd_payload_buf #(
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_idx  (idx[IDX_W-1:0]),
    .wr_data (rx_data),
    .rd_idx  (idx[IDX_W-1:0]),
    .rd_data (buf_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sum       <= 8'h00;
      base_addr <= 8'h00;
      len       <= 8'h00;
      idx       <= 8'h00;
      timer     <= '0;
      rx_ready  <= 1'b1;
      reg_wr_en <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= ERR_CSUM;
    end else begin
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      reg_wr_en <= 1'b0;

      if (in_pkt && !xfer) begin
        timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end

      if (xfer && state != ST_IDLE) begin
        sum <= sum_nxt;
      end

      if (timeout) begin
        state    <= ST_IDLE;
        pkt_err  <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else begin
        case (state)
          ST_IDLE: begin
            sum <= 8'h00;
            if (xfer && rx_data == SYNC_BYTE) begin
              state <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (xfer) begin
              if (rx_data == CMD_WRITE) begin
                state <= ST_ADDR;
              end else begin
                state    <= ST_IDLE;
                pkt_err  <= 1'b1;
                err_code <= ERR_CMD;
              end
            end
          end
          ST_ADDR: begin
            if (xfer) begin
              base_addr <= rx_data;
              state     <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (xfer) begin
              len <= rx_data;
              idx <= 8'h00;
              if (rx_data == 8'h00) begin
                state <= ST_CSUM;
              end else if (rx_data > MAX_LEN_B) begin
                state    <= ST_IDLE;
                pkt_err  <= 1'b1;
                err_code <= ERR_LEN;
              end else begin
                state <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (xfer) begin
              if (idx == len - 8'd1) begin
                idx   <= 8'h00;
                state <= ST_CSUM;
              end else begin
                idx <= idx + 8'd1;
              end
            end
          end
          ST_CSUM: begin
            if (xfer) begin
              if (sum_nxt != 8'h00) begin
                state    <= ST_IDLE;
                pkt_err  <= 1'b1;
                err_code <= ERR_CSUM;
              end else if (len == 8'h00) begin
                state  <= ST_IDLE;
                pkt_ok <= 1'b1;
              end else begin
                // First write issues on the same edge so COMMIT spans exactly LEN cycles.
                state     <= ST_COMMIT;
                rx_ready  <= 1'b0;
                reg_wr_en <= 1'b1;
                reg_addr  <= base_addr;
                reg_wdata <= buf_rdata;
                pkt_ok    <= (len == 8'd1);
                idx       <= 8'd1;
              end
            end
          end
          ST_COMMIT: begin
            if (idx == len) begin
              state    <= ST_IDLE;
              rx_ready <= 1'b1;
              idx      <= 8'h00;
            end else begin
              reg_wr_en <= 1'b1;
              reg_addr  <= base_addr + idx;
              reg_wdata <= buf_rdata;
              pkt_ok    <= (idx + 8'd1 == len);
              idx       <= idx + 8'd1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            rx_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_cmd_parser.sv
// tb/tb_usb_cmd_parser.sv - scoreboard bench for usb_cmd_parser
module tb_usb_cmd_parser;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       ok;
    logic       err;
    logic [1:0] code;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       reg_wr_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;
  logic       busy;

  int         total;
  int         bad;
  ev_t        exp_q[$];
  logic [7:0] pkt[$];
  bit         more;

  usb_cmd_parser #(
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .reg_wr_en (reg_wr_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic ev_t mk(input logic wr, input logic [7:0] a, input logic [7:0] d,
                             input logic ok, input logic err, input logic [1:0] code);
    ev_t e;
    e.wr = wr; e.addr = a; e.data = d; e.ok = ok; e.err = err; e.code = code;
    return e;
  endfunction

  // Output monitor: every strobe cycle must match the head of the expectation queue.
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      more = 1'b0;
    end else begin
      if (more) check("wr_gap", reg_wr_en, 1);
      more = 1'b0;
      if (reg_wr_en || pkt_ok || pkt_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_evt", {reg_wr_en, pkt_ok, pkt_err}, 0);
        end else begin
          e = exp_q.pop_front();
          check("reg_wr_en", reg_wr_en, e.wr);
          check("pkt_ok", pkt_ok, e.ok);
          check("pkt_err", pkt_err, e.err);
          if (e.wr) begin
            check("reg_addr", reg_addr, e.addr);
            check("reg_wdata", reg_wdata, e.data);
            check("rx_ready_commit", rx_ready, 0);
            more = !e.ok;
          end
          if (e.err) check("err_code", err_code, e.code);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("send_stall", 0, 1);
    @(posedge clk);
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Reference model: derive expected strobes from the packet bytes, then drive them.
  task automatic send_pkt(input bit model);
    logic [7:0] s;
    int         l;
    if (model) begin
      l = int'(pkt[3]);
      if (pkt[1] != 8'h01) begin
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd1));
      end else if (l > 16) begin
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd2));
      end else begin
        s = 8'h00;
        for (int i = 1; i < pkt.size(); i++) s = s + pkt[i];
        if (s != 8'h00) begin
          exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd0));
        end else if (l == 0) begin
          exp_q.push_back(mk(0, 0, 0, 1, 0, 2'd0));
        end else begin
          for (int i = 0; i < l; i++)
            exp_q.push_back(mk(1, pkt[2] + 8'(i), pkt[4+i], (i == l - 1), 0, 2'd0));
        end
      end
    end
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int k;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_outs", {reg_wr_en, reg_addr, reg_wdata, pkt_ok, pkt_err, err_code, busy}, 0);
    rst_n = 1'b1;
    go_idle(2);

    // Three-byte write, then commit starts the cycle after CSUM.
    pkt = '{8'hA5, 8'h01, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h86};
    send_pkt(1);
    @(negedge clk);
    rx_valid = 1'b0;
    check("commit_start", reg_wr_en, 1);
    check("busy_commit", busy, 1);
    drain();
    go_idle(2);

    // Bad checksum, bad CMD, oversize LEN, then back-to-back valid packets.
    pkt = '{8'hA5, 8'h01, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    send_pkt(1);
    pkt = '{8'hA5, 8'h02};
    send_pkt(1);
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h11};
    send_pkt(1);
    pkt = '{8'hA5, 8'h01, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h99};
    send_pkt(1);
    pkt = '{8'hA5, 8'h01, 8'h30, 8'h02, 8'hA5, 8'h5A, 8'hCE};
    send_pkt(1);
    go_idle(1);
    drain();
    go_idle(2);
    check("idle_not_busy", busy, 0);

    // Junk before SYNC, then LEN=0 packet: pkt_ok the cycle after CSUM.
    pkt = '{8'h00, 8'hFF, 8'h3C};
    send_pkt(0);
    pkt = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'hDF};
    send_pkt(1);
    @(negedge clk);
    rx_valid = 1'b0;
    check("len0_ok", pkt_ok, 1);
    drain();
    go_idle(2);

    // Timeout with rx_valid held low after CMD.
    exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd3));
    send_byte(8'hA5);
    send_byte(8'h01);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (pkt_err) begin
        k = i;
        break;
      end
    end
    check("timeout_cycle", k, 9);
    drain();
    go_idle(2);

    // Byte arriving in the timeout cycle is discarded.
    exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd3));
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rx_valid = (i == 8);
      rx_data  = 8'h10;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("timeout_vs_byte", pkt_err, 1);
    check("timeout_busy", busy, 0);
    drain();
    pkt = '{8'hA5, 8'h01, 8'h50, 8'h01, 8'h77, 8'h37};
    send_pkt(1);
    go_idle(1);
    drain();
    go_idle(2);
    check("err_code_held", err_code, 3);

    // Reset asserted after two writes of a LEN=4 commit.
    exp_q.push_back(mk(1, 8'h40, 8'h01, 0, 0, 2'd0));
    exp_q.push_back(mk(1, 8'h41, 8'h02, 0, 0, 2'd0));
    pkt = '{8'hA5, 8'h01, 8'h40, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hB1};
    send_pkt(0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_abort_wr", reg_wr_en, 0);
    check("rst_abort_ready", rx_ready, 1);
    check("rst_abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    go_idle(6);
    check("rst_abort_sb", exp_q.size(), 0);
    exp_q.delete();

    // Parser is functional again after the abort.
    pkt = '{8'hA5, 8'h01, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h86};
    send_pkt(1);
    go_idle(1);
    drain();
    go_idle(3);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
